// File: rtl/slot_cfg_sched.sv
// Virtual-slot card table sequencer: loads the default table after reset or on restore,
// then arbitrates read/write transactions from two requesters with write readback.
module slot_cfg_sched #(
    parameter logic [63:0] SLOT_CARDS = 64'h0   // slot n card ID in bits [8n+7:8n]
) (
    input  logic       clk_logic,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_wr,
    input  logic [2:0] req_slot0,
    input  logic [2:0] req_slot1,
    input  logic [7:0] req_card0,
    input  logic [7:0] req_card1,
    input  logic       restore,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    output logic       err,
    output logic [2:0] cfg_slot,
    output logic       cfg_wr,
    output logic [7:0] cfg_card_i,
    input  logic [7:0] cfg_card_o,
    output logic       card_changed,
    output logic [2:0] changed_slot,
    output logic       init_done,
    output logic       busy
);

    // state   | meaning
    // INIT    | writing default card table, one slot per cycle
    // IDLE    | waiting for restore or a request
    // ISSUE   | config port driven with the granted transaction
    // SETTLE  | pre-write value visible on cfg_card_o, captured as old
    // CAPTURE | post-write value visible, captured as new
    // RESP    | ack pulse to the granted requester
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_SETTLE, S_CAPTURE, S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic       last_q, last_d;
    logic       gnt_q, gnt_d;
    logic       tx_wr_q, tx_wr_d;
    logic [2:0] tx_slot_q, tx_slot_d;
    logic [7:0] tx_card_q, tx_card_d;
    logic [7:0] old_q, old_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic [2:0] cfg_slot_q, cfg_slot_d;
    logic       cfg_wr_q, cfg_wr_d;
    logic [7:0] cfg_card_q, cfg_card_d;
    logic       chg_q, chg_d;
    logic [2:0] chg_slot_q, chg_slot_d;
    logic       init_done_q, init_done_d;
    logic       pick;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        tx_wr_d     = tx_wr_q;
        tx_slot_d   = tx_slot_q;
        tx_card_d   = tx_card_q;
        old_d       = old_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cfg_slot_d  = cfg_slot_q;
        cfg_wr_d    = 1'b0;
        cfg_card_d  = cfg_card_q;
        chg_d       = 1'b0;
        chg_slot_d  = chg_slot_q;
        init_done_d = init_done_q;
        pick        = (req == 2'b11) ? ~last_q : req[1];

        case (state_q)
            S_INIT: begin
                // Config outputs are registered, so the ninth INIT edge only closes the load.
                if (init_cnt_q[3]) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    cfg_slot_d  = 3'd0;
                    cfg_card_d  = 8'd0;
                end else begin
                    cfg_wr_d   = 1'b1;
                    cfg_slot_d = init_cnt_q[2:0];
                    cfg_card_d = SLOT_CARDS[{init_cnt_q[2:0], 3'b000} +: 8];
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            S_IDLE: begin
                if (restore) begin
                    state_d    = S_INIT;
                    init_cnt_d = 4'd0;
                end else if (req != 2'b00) begin
                    state_d    = S_ISSUE;
                    gnt_d      = pick;
                    last_d     = pick;
                    tx_wr_d    = req_wr[pick];
                    tx_slot_d  = pick ? req_slot1 : req_slot0;
                    tx_card_d  = pick ? req_card1 : req_card0;
                    cfg_wr_d   = req_wr[pick];
                    cfg_slot_d = pick ? req_slot1 : req_slot0;
                    cfg_card_d = pick ? req_card1 : req_card0;
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                old_d   = cfg_card_o;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rdata_d = cfg_card_o;
                if (tx_wr_q) begin
                    err_d = (cfg_card_o != tx_card_q);
                    if (cfg_card_o != old_q) begin
                        chg_d      = 1'b1;
                        chg_slot_d = tx_slot_q;
                    end
                end else begin
                    err_d = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_INIT;
                init_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_logic or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= 4'd0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            tx_wr_q     <= 1'b0;
            tx_slot_q   <= 3'd0;
            tx_card_q   <= 8'd0;
            old_q       <= 8'd0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
            cfg_slot_q  <= 3'd0;
            cfg_wr_q    <= 1'b0;
            cfg_card_q  <= 8'd0;
            chg_q       <= 1'b0;
            chg_slot_q  <= 3'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            tx_wr_q     <= tx_wr_d;
            tx_slot_q   <= tx_slot_d;
            tx_card_q   <= tx_card_d;
            old_q       <= old_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cfg_slot_q  <= cfg_slot_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_card_q  <= cfg_card_d;
            chg_q       <= chg_d;
            chg_slot_q  <= chg_slot_d;
            init_done_q <= init_done_d;
        end
    end

    assign ack          = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy         = (state_q != S_IDLE);
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign cfg_slot     = cfg_slot_q;
    assign cfg_wr       = cfg_wr_q;
    assign cfg_card_i   = cfg_card_q;
    assign card_changed = chg_q;
    assign changed_slot = chg_slot_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_slot_cfg_sched.sv
// Directed bench for slot_cfg_sched with a behavioural slotmaker table (registered read port).
module tb_slot_cfg_sched;

    localparam logic [63:0] CARDS = 64'h0002_0005_0000_0000;

    logic       clk_logic = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] req_wr = 2'b00;
    logic [2:0] req_slot0 = 3'd0;
    logic [2:0] req_slot1 = 3'd0;
    logic [7:0] req_card0 = 8'd0;
    logic [7:0] req_card1 = 8'd0;
    logic       restore = 1'b0;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic       err;
    logic [2:0] cfg_slot;
    logic       cfg_wr;
    logic [7:0] cfg_card_i;
    logic [7:0] cfg_card_o;
    logic       card_changed;
    logic [2:0] changed_slot;
    logic       init_done;
    logic       busy;

    logic [7:0] mem [8];
    logic [7:0] rd_q;
    logic       stuck = 1'b0;
    logic [7:0] exp_cards [8];

    int checks = 0;
    int errors = 0;
    int got_lat, got_wrcnt, cc_seen;
    logic [1:0] got_ack;
    logic [7:0] got_rdata;
    logic       got_err, got_cc;
    logic [2:0] got_cs;

    slot_cfg_sched #(.SLOT_CARDS(CARDS)) dut (
        .clk_logic(clk_logic), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_slot0(req_slot0), .req_slot1(req_slot1),
        .req_card0(req_card0), .req_card1(req_card1), .restore(restore),
        .ack(ack), .rdata(rdata), .err(err), .cfg_slot(cfg_slot), .cfg_wr(cfg_wr),
        .cfg_card_i(cfg_card_i), .cfg_card_o(cfg_card_o), .card_changed(card_changed),
        .changed_slot(changed_slot), .init_done(init_done), .busy(busy)
    );

    always #5 clk_logic = ~clk_logic;

    always @(posedge clk_logic) begin
        if (cfg_wr) mem[cfg_slot] <= cfg_card_i;
        rd_q <= mem[cfg_slot];
    end
    assign cfg_card_o = stuck ? 8'h00 : rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_init(input logic done_during);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_logic);
            chk("init_wr", cfg_wr, 1);
            chk("init_slot", cfg_slot, k);
            chk("init_card", cfg_card_i, exp_cards[k]);
            chk("init_done_during", init_done, done_during);
            chk("init_busy", busy, 1);
        end
        @(negedge clk_logic);
        chk("init_end_done", init_done, 1);
        chk("init_end_busy", busy, 0);
        chk("init_end_wr", cfg_wr, 0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) @(negedge clk_logic);
        chk("wait_idle", busy, 0);
    endtask

    task automatic run_txn(input int r, input logic wr, input logic [2:0] slot, input logic [7:0] card);
        wait_idle();
        got_ack = 2'b00; got_lat = 99; got_wrcnt = 0; cc_seen = 0;
        got_rdata = 8'hxx; got_err = 1'bx; got_cc = 1'bx; got_cs = 3'bxxx;
        if (r == 0) begin req_wr[0] = wr; req_slot0 = slot; req_card0 = card; end
        else        begin req_wr[1] = wr; req_slot1 = slot; req_card1 = card; end
        req[r] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_logic);
            got_wrcnt += int'(cfg_wr);
            cc_seen   += int'(card_changed);
            if (ack != 2'b00) begin
                got_ack = ack; got_rdata = rdata; got_err = err;
                got_cc = card_changed; got_cs = changed_slot; got_lat = n;
                break;
            end
        end
        req[r] = 1'b0;
    endtask

    initial begin
        int nack, prev;
        exp_cards = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02, 8'h00};

        #2;
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_cfg_slot", cfg_slot, 0);
        chk("rst_cfg_wr", cfg_wr, 0);
        chk("rst_cfg_card", cfg_card_i, 0);
        chk("rst_cc", card_changed, 0);
        chk("rst_cs", changed_slot, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        @(negedge clk_logic);
        @(negedge clk_logic);
        rst_n = 1'b1;
        check_init(1'b0);

        run_txn(0, 1'b0, 3'd4, 8'h00);
        chk("rd4_lat", got_lat, 4);
        chk("rd4_ack", got_ack, 2'b01);
        chk("rd4_rdata", got_rdata, 8'h05);
        chk("rd4_err", got_err, 0);
        chk("rd4_wrcnt", got_wrcnt, 0);
        chk("rd4_cc", cc_seen, 0);

        run_txn(0, 1'b1, 3'd4, 8'h07);
        chk("wr4_lat", got_lat, 4);
        chk("wr4_ack", got_ack, 2'b01);
        chk("wr4_rdata", got_rdata, 8'h07);
        chk("wr4_err", got_err, 0);
        chk("wr4_cc", got_cc, 1);
        chk("wr4_cs", got_cs, 4);
        chk("wr4_wrcnt", got_wrcnt, 1);

        run_txn(1, 1'b1, 3'd4, 8'h07);
        chk("rewr4_lat", got_lat, 4);
        chk("rewr4_ack", got_ack, 2'b10);
        chk("rewr4_err", got_err, 0);
        chk("rewr4_cc", cc_seen, 0);
        chk("rewr4_cs_held", got_cs, 4);

        // requester 1 was granted last, so requester 0 goes first
        wait_idle();
        req_wr = 2'b01; req_slot0 = 3'd1; req_card0 = 8'h11; req_slot1 = 3'd1; req_card1 = 8'h00;
        req = 2'b11;
        nack = 0; prev = 0;
        for (int n = 1; n <= 40 && nack < 4; n++) begin
            @(negedge clk_logic);
            if (ack != 2'b00) begin
                chk("rr_ack", ack, (nack % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_rdata", rdata, 8'h11);
                if (nack > 0) chk("rr_spacing", n - prev, 5);
                prev = n;
                nack++;
            end
        end
        req = 2'b00;
        chk("rr_count", nack, 4);

        stuck = 1'b1;
        run_txn(0, 1'b1, 3'd2, 8'h03);
        stuck = 1'b0;
        chk("stuck_ack", got_ack, 2'b01);
        chk("stuck_err", got_err, 1);
        chk("stuck_rdata", got_rdata, 8'h00);
        chk("stuck_cc", cc_seen, 0);

        wait_idle();
        req_wr[0] = 1'b1; req_slot0 = 3'd3; req_card0 = 8'h09;
        req[0] = 1'b1;
        @(negedge clk_logic);
        chk("mid_issue_wr", cfg_wr, 1);
        @(negedge clk_logic);
        rst_n = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cfg_slot", cfg_slot, 0);
        chk("mid_rst_cfg_wr", cfg_wr, 0);
        chk("mid_rst_cfg_card", cfg_card_i, 0);
        chk("mid_rst_cs", changed_slot, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_busy", busy, 1);
        @(negedge clk_logic);
        chk("mid_rst_no_ack", ack, 0);
        rst_n = 1'b1;
        check_init(1'b0);

        req_wr[0] = 1'b1; req_slot0 = 3'd5; req_card0 = 8'h44;
        req[0] = 1'b1;
        restore = 1'b1;
        @(negedge clk_logic);
        restore = 1'b0;
        chk("restore_busy", busy, 1);
        chk("restore_no_ack", ack, 0);
        check_init(1'b1);
        got_lat = 99; got_ack = 2'b00;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk_logic);
            if (ack != 2'b00) begin
                got_ack = ack; got_lat = n; got_rdata = rdata;
                got_cc = card_changed; got_cs = changed_slot;
                break;
            end
        end
        req[0] = 1'b0;
        chk("restore_req_lat", got_lat, 4);
        chk("restore_req_ack", got_ack, 2'b01);
        chk("restore_req_rdata", got_rdata, 8'h44);
        chk("restore_req_cc", got_cc, 1);
        chk("restore_req_cs", got_cs, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
